// File: rtl/bn_engine_arbiter.sv
// ---------------------------------------------------------------------------
// bn_engine_arbiter
//
// Purpose:
//   Round-robin scheduler that shares a single batch-normalisation engine
//   between N_REQ upstream requesters. It arbitrates, drives the engine input
//   handshake and the external data-mux select (bn_sel), waits for the engine
//   result and hands the response back to the requester that was granted.
//   The block is control-only; the 64 x 16-bit datapath mux lives outside.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (0 = in reset)
//   req_valid     per-requester job request, held until req_ack
//   req_ack       one-cycle pulse: job accepted by the engine
//   resp_valid    result available, held until resp_ready of that requester
//   resp_ready    requester consumes the result
//   resp_err      qualifies resp_valid: 1 = job aborted by watchdog
//   bn_valid_in   engine input valid
//   bn_ready_out  engine ready
//   bn_valid_out  engine result pulse
//   bn_sel        mux select, equals the granted requester
//   busy          high whenever the FSM is not idle
//   jobs_done     saturating count of completed non-error jobs
//   err_spurious  sticky: engine result pulse seen outside WAIT
//   timeout_err   sticky: completion watchdog fired
//
// Configuration:
//   BN_TIMEOUT_EN  when defined, a watchdog aborts a job that has not
//                  completed within TIMEOUT_CYC cycles of WAIT. When not
//                  defined, WAIT lasts until bn_valid_out and resp_err /
//                  timeout_err stay 0.
// ---------------------------------------------------------------------------
module bn_engine_arbiter #(
    parameter int N_REQ       = 2,
    parameter int SEL_W       = 1,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ack,
    output logic [N_REQ-1:0]  resp_valid,
    input  logic [N_REQ-1:0]  resp_ready,
    output logic              resp_err,
    output logic              bn_valid_in,
    input  logic              bn_ready_out,
    input  logic              bn_valid_out,
    output logic [SEL_W-1:0]  bn_sel,
    output logic              busy,
    output logic [CNT_W-1:0]  jobs_done,
    output logic              err_spurious,
    output logic              timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // One extra bit so that (index + step) cannot overflow before the wrap.
    localparam logic [SEL_W:0] N_REQ_W = (SEL_W + 1)'(N_REQ);

    // Modulo-N_REQ add of a requester index and a small step.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] idx,
                                                   input logic [SEL_W:0]   step);
        logic [SEL_W:0] sum;
        sum = {1'b0, idx} + step;
        if (sum >= N_REQ_W) begin
            sum = sum - N_REQ_W;
        end else begin
            sum = sum;
        end
        return sum[SEL_W-1:0];
    endfunction

    // One-hot vector with only the bit of requester idx set.
    function automatic logic [N_REQ-1:0] id_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = {N_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Saturating increment of the job counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [1:0]       state_r;
    logic [SEL_W-1:0] rr_ptr_r;
    logic [SEL_W-1:0] bn_sel_r;
    logic             bn_valid_in_r;
    logic [N_REQ-1:0] req_ack_r;
    logic [N_REQ-1:0] resp_valid_r;
    logic             resp_err_r;
    logic             busy_r;
    logic [CNT_W-1:0] jobs_done_r;
    logic             err_spurious_r;

    logic             pick_hit_s;
    logic [SEL_W-1:0] pick_id_s;
    logic [SEL_W-1:0] cand_s;
    logic             wd_fire_s;

    // Round-robin pick: first requester at or after rr_ptr_r, wrapping.
    always_comb begin
        pick_hit_s = 1'b0;
        pick_id_s  = {SEL_W{1'b0}};
        cand_s     = {SEL_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = wrap_add(rr_ptr_r, (SEL_W + 1)'(i));
            if (!pick_hit_s && req_valid[cand_s]) begin
                pick_hit_s = 1'b1;
                pick_id_s  = cand_s;
            end else begin
                pick_id_s  = pick_id_s;
            end
        end
    end

`ifdef BN_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_err_r;

    // Fires on the TIMEOUT_CYC-th WAIT cycle unless the engine answers in it.
    assign wd_fire_s = (state_r == ST_WAIT) && !bn_valid_out && (wd_cnt_r == WD_LAST);

    // Watchdog counter: cleared on the engine handshake, counts only in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_ISSUE) && bn_ready_out) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky watchdog flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err_r <= 1'b0;
        end else if (wd_fire_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign wd_fire_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Main FSM: arbitration, engine handshake, response hold and job count.
    // bn_sel_r doubles as the latched grant and is only rewritten in IDLE,
    // so it stays stable from ISSUE entry until RESP exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= {SEL_W{1'b0}};
            bn_sel_r      <= {SEL_W{1'b0}};
            bn_valid_in_r <= 1'b0;
            req_ack_r     <= {N_REQ{1'b0}};
            resp_valid_r  <= {N_REQ{1'b0}};
            resp_err_r    <= 1'b0;
            busy_r        <= 1'b0;
            jobs_done_r   <= {CNT_W{1'b0}};
        end else begin
            req_ack_r <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (pick_hit_s) begin
                        bn_sel_r      <= pick_id_s;
                        bn_valid_in_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bn_ready_out) begin
                        bn_valid_in_r <= 1'b0;
                        req_ack_r     <= id_onehot(bn_sel_r);
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bn_valid_out) begin
                        resp_valid_r <= id_onehot(bn_sel_r);
                        resp_err_r   <= 1'b0;
                        state_r      <= ST_RESP;
                    end else if (wd_fire_s) begin
                        resp_valid_r <= id_onehot(bn_sel_r);
                        resp_err_r   <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the granted requester's ready bit releases the response.
                    if (resp_ready[bn_sel_r]) begin
                        resp_valid_r <= {N_REQ{1'b0}};
                        resp_err_r   <= 1'b0;
                        rr_ptr_r     <= wrap_add(bn_sel_r, (SEL_W + 1)'(1));
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                        if (!resp_err_r) begin
                            jobs_done_r <= sat_inc(jobs_done_r);
                        end
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bn_valid_in_r <= 1'b0;
                    resp_valid_r  <= {N_REQ{1'b0}};
                    resp_err_r    <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for an engine result pulse that no job is waiting for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_spurious_r <= 1'b0;
        end else if (bn_valid_out && (state_r != ST_WAIT)) begin
            err_spurious_r <= 1'b1;
        end else begin
            err_spurious_r <= err_spurious_r;
        end
    end

    assign req_ack      = req_ack_r;
    assign resp_valid   = resp_valid_r;
    assign resp_err     = resp_err_r;
    assign bn_valid_in  = bn_valid_in_r;
    assign bn_sel       = bn_sel_r;
    assign busy         = busy_r;
    assign jobs_done    = jobs_done_r;
    assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_bn_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bn_engine_arbiter
//
// Self-checking bench for bn_engine_arbiter (N_REQ = 2, TIMEOUT_CYC = 16).
// A small behavioural engine model answers the handshake with a programmable
// stall and completion delay. Expected grant ids are queued when a request is
// driven and popped when the matching resp_valid appears.
// ---------------------------------------------------------------------------
module tb_bn_engine_arbiter;

    localparam int N_REQ       = 2;
    localparam int SEL_W       = 1;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ack;
    logic [N_REQ-1:0] resp_valid;
    logic [N_REQ-1:0] resp_ready;
    logic             resp_err;
    logic             bn_valid_in;
    logic             bn_ready_out;
    logic             bn_valid_out;
    logic [SEL_W-1:0] bn_sel;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;
    logic             err_spurious;
    logic             timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    // engine model controls / state
    int   eng_ph     = 0;
    int   stall_left = 0;
    int   done_delay = 10;   // 0 = engine never answers
    int   wait_cnt   = 0;
    int   vout_cyc   = -100;
    logic spur_pulse = 1'b0;

    bn_engine_arbiter #(
        .N_REQ(N_REQ), .SEL_W(SEL_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .bn_valid_in(bn_valid_in), .bn_ready_out(bn_ready_out), .bn_valid_out(bn_valid_out),
        .bn_sel(bn_sel), .busy(busy), .jobs_done(jobs_done),
        .err_spurious(err_spurious), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and update the engine model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bn_valid_out = 1'b0;
        if (spur_pulse) begin
            bn_valid_out = 1'b1;
            spur_pulse   = 1'b0;
            vout_cyc     = cyc;
        end
        case (eng_ph)
            0: begin
                if (bn_valid_in && stall_left > 0) begin
                    bn_ready_out = 1'b0;
                    stall_left--;
                end else if (bn_valid_in) begin
                    bn_ready_out = 1'b1;
                    eng_ph = 1;
                end else begin
                    bn_ready_out = 1'b0;
                end
            end
            1: begin
                bn_ready_out = 1'b0;
                wait_cnt = 0;
                eng_ph = 2;
            end
            default: ;
        endcase
        if (eng_ph == 2) begin
            wait_cnt++;
            if (done_delay > 0 && wait_cnt == done_delay) begin
                bn_valid_out = 1'b1;
                vout_cyc = cyc;
                eng_ph = 0;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
        eng_ph = 0; stall_left = 0; bn_ready_out = 1'b0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    // Drive one job, drop the request on ack, consume the first response.
    task automatic run_job(input logic [1:0] req, output logic [1:0] got, output logic got_err);
        got = 2'b00; got_err = 1'b0;
        req_valid = req;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (req_ack != 2'b00) req_valid = req_valid & ~req_ack;
            if (resp_valid != 2'b00) begin
                got = resp_valid; got_err = resp_err; resp_ready = resp_valid;
                break;
            end
        end
        tick();
        resp_ready = 2'b00; req_valid = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
        bn_ready_out = 1'b0; bn_valid_out = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ack, resp_valid, resp_err, bn_valid_in, bn_sel, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %0h, expected 0", {req_ack, resp_valid, resp_err, bn_valid_in, bn_sel, busy});
        end
        n_checks++;
        if (jobs_done !== 16'd0) begin
            n_fail++; $display("FAIL reset_jobs_done: got %0d, expected 0", jobs_done);
        end
        n_checks++;
        if ({err_spurious, timeout_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_sticky: got %b, expected 00", {err_spurious, timeout_err});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        int acks = 0; int ack_cyc = -1; bit done = 0; int e;
        logic [1:0] exp_oh;
        done_delay = 10; stall_left = 0;
        tick();
        req_valid = 2'b01; exp_q.push_back(0);
        n_checks++;
        if (bn_valid_in !== 1'b0) begin
            n_fail++; $display("FAIL single_vin_early: got %b, expected 0", bn_valid_in);
        end
        tick();
        n_checks++;
        if ({bn_valid_in, bn_sel, busy} !== 3'b101) begin
            n_fail++; $display("FAIL single_issue: got %b, expected 101", {bn_valid_in, bn_sel, busy});
        end
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (req_ack != 2'b00) begin
                acks++; ack_cyc = cyc;
                n_checks++;
                if (req_ack !== 2'b01) begin
                    n_fail++; $display("FAIL single_ack: got %b, expected 01", req_ack);
                end
                req_valid = req_valid & ~req_ack;
            end
            if (resp_valid != 2'b00 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                n_checks++;
                if (resp_valid !== exp_oh) begin
                    n_fail++; $display("FAIL single_resp: got %b, expected %b", resp_valid, exp_oh);
                end
                n_checks++;
                if (cyc != vout_cyc + 1 || cyc != ack_cyc + 10) begin
                    n_fail++; $display("FAIL single_resp_lat: got %0d, expected %0d", cyc - ack_cyc, 10);
                end
                resp_ready = resp_valid; done = 1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL single_timeout: got no response, expected resp_valid");
        end
        tick();
        resp_ready = 2'b00;
        n_checks++;
        if (acks != 1) begin
            n_fail++; $display("FAIL single_ack_pulses: got %0d, expected 1", acks);
        end
        n_checks++;
        if ({resp_valid, busy} !== 3'b000 || jobs_done !== 16'd1) begin
            n_fail++; $display("FAIL single_done: got rv=%b busy=%b jobs=%0d, expected 00/0/1", resp_valid, busy, jobs_done);
        end
    endtask

    task automatic test_fairness();
        int got = 0; int e;
        logic [1:0] exp_oh;
        apply_reset();
        done_delay = 3;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) exp_q.push_back(j % 2);
        for (int k = 0; k < 400 && got < 4; k++) begin
            tick();
            if (req_ack != 2'b00) begin
                n_checks++;
                if (!$onehot(req_ack)) begin
                    n_fail++; $display("FAIL fair_ack_overlap: got %b, expected one-hot", req_ack);
                end
            end
            if (resp_valid != 2'b00 && resp_ready == 2'b00 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                n_checks++;
                if (bn_sel !== SEL_W'(e) || resp_valid !== exp_oh) begin
                    n_fail++; $display("FAIL fair_order: got sel=%0d rv=%b, expected sel=%0d rv=%b", bn_sel, resp_valid, e, exp_oh);
                end
                resp_ready = resp_valid; got++;
            end else begin
                resp_ready = 2'b00;
            end
        end
        if (got < 4) begin
            n_checks++; n_fail++; $display("FAIL fair_timeout: got %0d jobs, expected 4", got);
        end
        tick();
        resp_ready = 2'b00; req_valid = 2'b00;
        tick();
        n_checks++;
        if (jobs_done !== 16'd4 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fair_jobs: got %0d busy=%b, expected 4 busy=0", jobs_done, busy);
        end
    endtask

    task automatic test_backpressure();
        int vin_cnt = 0; int sel_bad = 0; int hold = 0; bit done = 0; int e;
        logic [1:0] exp_oh;
        stall_left = 7; done_delay = 3;
        req_valid = 2'b10; exp_q.push_back(1);
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            if (bn_valid_in) vin_cnt++;
            if (busy && bn_sel !== 1'b1) sel_bad++;
            if (req_ack != 2'b00) req_valid = req_valid & ~req_ack;
            if (resp_valid != 2'b00) begin
                hold++;
                if (hold == 1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                    n_checks++;
                    if (resp_valid !== exp_oh) begin
                        n_fail++; $display("FAIL bp_resp: got %b, expected %b", resp_valid, exp_oh);
                    end
                end
                // the non-granted ready bit must not release the response
                resp_ready = (hold == 6) ? 2'b10 : 2'b01;
            end else if (hold > 0) begin
                done = 1; resp_ready = 2'b00;
            end
        end
        resp_ready = 2'b00;
        n_checks++;
        if (vin_cnt != 8) begin
            n_fail++; $display("FAIL bp_vin_len: got %0d, expected 8", vin_cnt);
        end
        n_checks++;
        if (sel_bad != 0) begin
            n_fail++; $display("FAIL bp_sel_stable: got %0d changes, expected 0", sel_bad);
        end
        n_checks++;
        if (hold != 6 || !done) begin
            n_fail++; $display("FAIL bp_resp_hold: got %0d, expected 6", hold);
        end
        n_checks++;
        if (jobs_done !== 16'd5) begin
            n_fail++; $display("FAIL bp_jobs: got %0d, expected 5", jobs_done);
        end
    endtask

    task automatic test_spurious_withdraw();
        bit done = 0; int e;
        logic [1:0] exp_oh;
        tick();
        n_checks++;
        if (err_spurious !== 1'b0) begin
            n_fail++; $display("FAIL spur_pre: got %b, expected 0", err_spurious);
        end
        spur_pulse = 1'b1;
        tick(); tick();
        n_checks++;
        if ({err_spurious, busy, resp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL spur_flag: got %b, expected 1000", {err_spurious, busy, resp_valid});
        end
        done_delay = 4;
        req_valid = 2'b10; exp_q.push_back(1);
        tick();
        n_checks++;
        if ({busy, bn_sel} !== 2'b11) begin
            n_fail++; $display("FAIL wd_grant: got %b, expected 11", {busy, bn_sel});
        end
        req_valid = 2'b00;   // withdrawn after grant
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (resp_valid != 2'b00 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                n_checks++;
                if (resp_valid !== exp_oh) begin
                    n_fail++; $display("FAIL wd_resp: got %b, expected %b", resp_valid, exp_oh);
                end
                resp_ready = resp_valid; done = 1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL wd_timeout: got no response, expected 10");
        end
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0] got; logic got_err; bit acked = 0; bit done = 0; int e;
        logic [1:0] exp_oh;
        done_delay = 3;
        exp_q.push_back(0);
        run_job(2'b01, got, got_err);
        e = exp_q.pop_front(); exp_oh = 2'b01 << e;
        n_checks++;
        if (got !== exp_oh) begin
            n_fail++; $display("FAIL rst_prejob: got %b, expected %b", got, exp_oh);
        end
        done_delay = 0;
        req_valid = 2'b01;
        for (int k = 0; k < 20 && !acked; k++) begin
            tick();
            if (req_ack != 2'b00) acked = 1;
        end
        req_valid = 2'b00;
        tick(); tick();
        n_checks++;
        if (!acked || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_wait: got busy=%b acked=%b, expected 1/1", busy, acked);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({req_ack, resp_valid, resp_err, bn_valid_in, bn_sel, busy, err_spurious} !== 9'h000) begin
            n_fail++; $display("FAIL rst_async_outs: got %0h, expected 0", {req_ack, resp_valid, resp_err, bn_valid_in, bn_sel, busy, err_spurious});
        end
        n_checks++;
        if (jobs_done !== 16'd0) begin
            n_fail++; $display("FAIL rst_async_jobs: got %0d, expected 0", jobs_done);
        end
        eng_ph = 0; bn_ready_out = 1'b0;
        tick();
        reset = 1'b1;
        done_delay = 3;
        req_valid = 2'b11; exp_q.push_back(0);
        tick();
        n_checks++;
        if ({busy, bn_sel} !== 2'b10) begin
            n_fail++; $display("FAIL rst_rr_ptr: got busy/sel %b, expected 10", {busy, bn_sel});
        end
        req_valid = 2'b00;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (resp_valid != 2'b00 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                n_checks++;
                if (resp_valid !== exp_oh) begin
                    n_fail++; $display("FAIL rst_post_resp: got %b, expected %b", resp_valid, exp_oh);
                end
                resp_ready = resp_valid; done = 1;
            end
        end
        tick();
        resp_ready = 2'b00;
        n_checks++;
        if (jobs_done !== 16'd1) begin
            n_fail++; $display("FAIL rst_post_jobs: got %0d, expected 1", jobs_done);
        end
    endtask

`ifdef BN_TIMEOUT_EN
    task automatic test_timeout();
        int ack_cyc = -1; bit done = 0; int e;
        logic [1:0] exp_oh; logic [CNT_W-1:0] jobs_before;
        jobs_before = jobs_done;
        done_delay = 0;
        req_valid = 2'b01; exp_q.push_back(0);
        for (int k = 0; k < 200 && !done; k++) begin
            tick();
            if (req_ack != 2'b00) begin
                ack_cyc = cyc; req_valid = req_valid & ~req_ack;
            end
            if (resp_valid != 2'b00 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); exp_oh = 2'b01 << e;
                n_checks++;
                if (resp_valid !== exp_oh || resp_err !== 1'b1 || timeout_err !== 1'b1) begin
                    n_fail++; $display("FAIL to_resp: got rv=%b err=%b to=%b, expected %b/1/1", resp_valid, resp_err, timeout_err, exp_oh);
                end
                n_checks++;
                if (cyc - ack_cyc != TIMEOUT_CYC) begin
                    n_fail++; $display("FAIL to_latency: got %0d, expected %0d", cyc - ack_cyc, TIMEOUT_CYC);
                end
                resp_ready = resp_valid; done = 1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL to_no_resp: got none, expected resp_err response");
        end
        tick();
        resp_ready = 2'b00;
        eng_ph = 0;
        n_checks++;
        if (jobs_done !== jobs_before) begin
            n_fail++; $display("FAIL to_jobs: got %0d, expected %0d", jobs_done, jobs_before);
        end
        spur_pulse = 1'b1;   // late engine answer
        tick(); tick();
        n_checks++;
        if (err_spurious !== 1'b1 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL to_late: got spur=%b to=%b, expected 1/1", err_spurious, timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [1:0] got; logic got_err; int e;
        logic [1:0] exp_oh;
        done_delay = 40;    // longer than TIMEOUT_CYC: no abort without the watchdog
        exp_q.push_back(1);
        run_job(2'b10, got, got_err);
        e = exp_q.pop_front(); exp_oh = 2'b01 << e;
        n_checks++;
        if (got !== exp_oh || got_err !== 1'b0) begin
            n_fail++; $display("FAIL nto_resp: got %b err=%b, expected %b err=0", got, got_err, exp_oh);
        end
        n_checks++;
        if (timeout_err !== 1'b0 || jobs_done !== 16'd2) begin
            n_fail++; $display("FAIL nto_flags: got to=%b jobs=%0d, expected 0/2", timeout_err, jobs_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_fairness();
        test_backpressure();
        test_spurious_withdraw();
        test_reset_mid_wait();
`ifdef BN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: got no completion, expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/bn_engine_arbiter.md
Name: bn_engine_arbiter

Overview:
- Control-only scheduler that shares one batch-normalisation engine (64 × 16-bit signed vector in/out, valid_in/ready_out/valid_out handshake) between N_REQ upstream network branches.
- Performs round-robin arbitration, drives the engine's input handshake and the data-mux select, waits for completion, and returns the response to the granting requester.
- The datapath mux lives outside this block and is steered by bn_sel.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- SEL_W, 1, width of bn_sel / grant_id; must equal clog2(N_REQ).
- TIMEOUT_CYC, 4096, engine completion watchdog limit in cycles (used only with BN_TIMEOUT_EN).
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  N_REQ  per-requester job request; held until req_ack.
- req_ack  out  N_REQ  one-cycle pulse, job accepted by engine.
- resp_valid  out  N_REQ  result available to requester; held until resp_ready.
- resp_ready  in  N_REQ  requester consumes the result.
- resp_err  out  1  qualifies resp_valid; 1 = job aborted by timeout.
- bn_valid_in  out  1  engine input valid.
- bn_ready_out  in  1  engine ready.
- bn_valid_out  in  1  engine result pulse.
- bn_sel  out  SEL_W  input/output mux select; equals the granted requester.
- busy  out  1  high in any state other than IDLE.
- jobs_done  out  CNT_W  saturating count of completed, non-error jobs.
- err_spurious  out  1  sticky; bn_valid_out seen outside WAIT.
- timeout_err  out  1  sticky; watchdog fired.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Round-robin pointer rr_ptr = 0.
  - All outputs are 0, including bn_sel, jobs_done and both sticky flags.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo N_REQ; the first set bit wins.
  - Latch grant_id, drive bn_sel = grant_id, go to ISSUE.
  - No request present: stay in IDLE.
  - Arbitration costs one cycle: bn_valid_in rises 1 cycle after req_valid is sampled.
- ISSUE:
  - bn_valid_in = 1; bn_sel stays stable.
  - On the first cycle with bn_ready_out = 1 (handshake):
    - next cycle req_ack[grant_id] = 1 for exactly one cycle;
    - bn_valid_in = 0;
    - go to WAIT and clear the watchdog counter.
  - A bn_ready_out stuck low holds ISSUE indefinitely; the watchdog does not run in ISSUE.
- WAIT:
  - bn_valid_out = 1 → resp_valid[grant_id] = 1 and resp_err = 0 next cycle, go to RESP.
- RESP:
  - Hold resp_valid[grant_id], resp_err and bn_sel until resp_ready[grant_id] = 1.
  - On that cycle:
    - drop resp_valid;
    - rr_ptr = (grant_id + 1) mod N_REQ;
    - jobs_done += 1 if resp_err = 0, saturating at all-ones;
    - go to IDLE.
  - Back-to-back jobs are allowed: IDLE re-arbitrates on the next cycle.
- Request withdrawal:
  - A req_valid dropped before grant is simply not chosen.
  - A req_valid dropped after grant is ignored; the job completes and resp_valid is still raised.
- bn_sel never changes between ISSUE entry and RESP exit.
- bn_valid_out while in IDLE, ISSUE or RESP:
  - set err_spurious;
  - no state change, no response.
- Reset asserted mid-job: immediate return to IDLE with all outputs 0; the job is lost and requesters must re-request.
- resp_ready on a non-granted bit is ignored.

Optional Feature:
- Macro BN_TIMEOUT_EN.
- Defined:
  - in WAIT a counter increments each cycle;
  - if it reaches TIMEOUT_CYC with no bn_valid_out, set timeout_err and go to RESP with resp_err = 1 and resp_valid[grant_id] = 1;
  - jobs_done does not increment for that job;
  - a late bn_valid_out arriving afterward sets err_spurious.
- Not defined:
  - no counter; WAIT lasts until bn_valid_out;
  - resp_err and timeout_err are tied to 0.

Test Plan:
1. Single job: reset released, req_valid = 01, engine ready = 1, valid_out 10 cycles after the handshake → bn_valid_in high 1 cycle after the request; req_ack = 01 one pulse; resp_valid = 01 the cycle after valid_out; jobs_done = 1 after resp_ready.
2. Fairness: req_valid = 11 held, 4 jobs completed → bn_sel sequence 0, 1, 0, 1; jobs_done = 4; no req_ack overlap.
3. Backpressure: bn_ready_out low for 7 cycles in ISSUE, then resp_ready delayed 5 cycles → bn_valid_in held 8 cycles; bn_sel constant; resp_valid held 6 cycles then drops.
4. Spurious/withdraw: bn_valid_out pulsed in IDLE → err_spurious = 1, stays IDLE. Separately, req_valid[1] dropped after grant → resp_valid[1] still asserted.
5. Reset mid-WAIT: reset pulled low for 1 cycle → all outputs 0 asynchronously, state IDLE, rr_ptr = 0, jobs_done = 0.
6. BN_TIMEOUT_EN with TIMEOUT_CYC = 16, engine never responds → resp_valid with resp_err = 1 after 16 WAIT cycles; timeout_err = 1; jobs_done unchanged.
